cache_ctrl_param: RTL

Parametrised successor to the single-word cache controller. Sits between the CPU load/store port, the tag/data cache array and a narrow external memory bus. Serves read hits from the cache and fills on a read miss with multi-beat bursts. Handles write-through stores with byte enables and no write-allocate. Data width, memory bus width and address width are generic, and beats with no enabled bytes are skipped.

---
 rtl/cache_ctrl_param.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_ctrl_param.sv
// cache_ctrl_param: parametrised cache controller between a CPU load/store
// port, a tag/data cache array and a narrow external memory bus.
//   - read hits are served from the array, read misses fill with a burst of
//     DATA_W/MEM_W memory beats (beat 0 in the word's LSBs)
//   - stores are write-through with byte enables, no write-allocate; beats
//     whose byte-enable slice is all zero are never issued
// Optional build macro MEM_TIMEOUT_EN: abort a memory beat that waits
// TIMEOUT_CYC cycles, answering with RDY and ERR. Without it ERR is always 0.
//
// Handshakes:
//   CPU side : RREQ/WE are held by the requester until the one-cycle RDY
//              pulse; the pulse cycle itself never starts a new request, so
//              a requester still holding its request while RDY=1 is not
//              served twice.
//   Mem side : MREQ (with MWE, MADDR, MDOUT) is held until a cycle with
//              MRDY=1; that cycle completes the beat and MDIN is sampled in
//              it. MRDY while MREQ=0 has no effect.
// The FSM state is held in the named enum signal `state` for observation.
module cache_ctrl_param #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_W       = 8,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  RREQ,
  input  logic                  WE,
  input  logic [ADDR_W-1:0]     ADDR,
  input  logic [DATA_W-1:0]     DIN,
  input  logic [DATA_W/8-1:0]   BE,
  output logic                  RDY,
  output logic [DATA_W-1:0]     DOUT,
  output logic                  ERR,
  input  logic                  FOUND,
  input  logic [DATA_W-1:0]     CDOUT,
  output logic                  CWE,
  output logic [DATA_W-1:0]     CDIN,
  output logic [DATA_W/8-1:0]   CBE,
  output logic [ADDR_W-1:0]     MADDR,
  output logic                  MREQ,
  output logic                  MWE,
  output logic [MEM_W-1:0]      MDOUT,
  input  logic [MEM_W-1:0]      MDIN,
  input  logic                  MRDY
);

  localparam int BEATS  = DATA_W / MEM_W;
  localparam int BPB    = MEM_W / 8;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    FILL   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t                       state;
  logic                         is_wr;
  logic [ADDR_W-1:0]            addr_r;
  logic [BEATS-1:0][MEM_W-1:0]  din_r;
  logic [BEATS-1:0][BPB-1:0]    be_r;
  logic [BEATS-1:0][MEM_W-1:0]  fill_buf;
  logic [BEAT_W-1:0]            beat;

  logic [BEATS-1:0]             beat_en;
  logic                         first_ok;
  logic [BEAT_W-1:0]            first_idx;
  logic                         next_ok;
  logic [BEAT_W-1:0]            next_idx;

`ifdef MEM_TIMEOUT_EN
  localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [TCNT_W-1:0]            tcnt;
  logic                         err_r;
`else
  // Constant 0: without the timeout the controller never reports an error
  // and the wait limit has no effect.
  assign ERR = (TIMEOUT_CYC < 0);
`endif

  // Byte address of a given beat of the latched request; wraps mod 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [BEAT_W-1:0] idx);
    return base + ADDR_W'(idx) * ADDR_W'(BPB);
  endfunction

  // Find the first enabled store beat, and the next enabled one after `beat`.
  always_comb begin
    beat_en   = '0;
    first_ok  = 1'b0;
    first_idx = '0;
    next_ok   = 1'b0;
    next_idx  = '0;
    for (int i = 0; i < BEATS; i++) begin
      beat_en[i] = |be_r[i];
    end
    // Scanning downward leaves the lowest matching index in place.
    for (int i = BEATS - 1; i >= 0; i--) begin
      if (beat_en[i]) begin
        first_ok  = 1'b1;
        first_idx = BEAT_W'(i);
      end
      if (beat_en[i] && (i > int'(beat))) begin
        next_ok  = 1'b1;
        next_idx = BEAT_W'(i);
      end
    end
  end

  // Controller FSM with all outputs registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      is_wr    <= 1'b0;
      addr_r   <= '0;
      din_r    <= '0;
      be_r     <= '0;
      fill_buf <= '0;
      beat     <= '0;
      RDY      <= 1'b0;
      DOUT     <= '0;
      CWE      <= 1'b0;
      CDIN     <= '0;
      CBE      <= '0;
      MADDR    <= '0;
      MREQ     <= 1'b0;
      MWE      <= 1'b0;
      MDOUT    <= '0;
`ifdef MEM_TIMEOUT_EN
      ERR      <= 1'b0;
      tcnt     <= '0;
      err_r    <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      RDY <= 1'b0;
      CWE <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      ERR <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef MEM_TIMEOUT_EN
          err_r <= 1'b0;
`endif
          // The RDY cycle belongs to the request just finished.
          if (!RDY) begin
            if (WE) begin
              is_wr  <= 1'b1;
              addr_r <= ADDR;
              din_r  <= DIN;
              be_r   <= BE;
              state  <= LOOKUP;
            end else if (RREQ) begin
              is_wr  <= 1'b0;
              addr_r <= ADDR;
              state  <= LOOKUP;
            end
          end
        end

        LOOKUP: begin
`ifdef MEM_TIMEOUT_EN
          tcnt <= '0;
`endif
          if (!is_wr) begin
            if (FOUND) begin
              DOUT  <= CDOUT;
              state <= DONE;
            end else begin
              beat  <= '0;
              MADDR <= addr_r;
              MREQ  <= 1'b1;
              MWE   <= 1'b0;
              state <= MEM_RD;
            end
          end else begin
            // Write-through: update the array only on a hit.
            if (FOUND) begin
              CWE  <= 1'b1;
              CDIN <= din_r;
              CBE  <= be_r;
            end
            beat <= first_idx;
            if (first_ok) begin
              MADDR <= beat_addr(addr_r, first_idx);
              MDOUT <= din_r[first_idx];
              MREQ  <= 1'b1;
              MWE   <= 1'b1;
              state <= MEM_WR;
            end else begin
              state <= DONE;
            end
          end
        end

        MEM_RD: begin
          if (MRDY) begin
            fill_buf[beat] <= MDIN;
`ifdef MEM_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (beat == LAST_BEAT) begin
              MREQ  <= 1'b0;
              state <= FILL;
            end else begin
              beat  <= beat + 1'b1;
              MADDR <= MADDR + ADDR_W'(BPB);
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
            // This is the TIMEOUT_CYC-th cycle of waiting: give up, no fill.
            MREQ  <= 1'b0;
            err_r <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end

        MEM_WR: begin
          if (MRDY) begin
`ifdef MEM_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (next_ok) begin
              beat  <= next_idx;
              MADDR <= beat_addr(addr_r, next_idx);
              MDOUT <= din_r[next_idx];
            end else begin
              MREQ  <= 1'b0;
              MWE   <= 1'b0;
              state <= DONE;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (tcnt == TCNT_W'(TIMEOUT_CYC - 1)) begin
            MREQ  <= 1'b0;
            MWE   <= 1'b0;
            err_r <= 1'b1;
            state <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end

        FILL: begin
          // Whole-line write of the assembled little-endian word.
          CWE   <= 1'b1;
          CBE   <= '1;
          CDIN  <= fill_buf;
          DOUT  <= fill_buf;
          state <= DONE;
        end

        DONE: begin
          RDY   <= 1'b1;
`ifdef MEM_TIMEOUT_EN
          ERR   <= err_r;
`endif
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
